uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
- Byte-stream command responder on the usb_uart pipeline. It sits in `hardware`, replacing the current loopback.
- Consumes host bytes from usb_uart's uart_out stream and returns one reply byte per command on usb_uart's uart_in stream.
- Exposes a small bank of 8-bit control registers; register 0 drives LED/blink control.
- Runs entirely in the clk_48mhz domain.

Parameters:
- NUM_REGS, 4, number of 8-bit registers; valid addresses are 0..NUM_REGS-1 (1..16).
- TIMEOUT_CYCLES, 4_800_000, idle cycles allowed between bytes of one command before the parse is abandoned (100 ms at 48 MHz); 0 disables the timeout.
- VERSION, 8'h01, byte returned by the 'V' command.

Ports:
- clk_48mhz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  command byte from usb_uart uart_out_data
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  responder accepts rx_data this cycle
- tx_data  out  8  reply byte to usb_uart uart_in_data
- tx_valid  out  1  reply valid
- tx_ready  in  1  usb_uart accepts reply
- reg_out  out  NUM_REGS*8  register bank; register n occupies bits [8n+7:8n]

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - reg_out = 0; tx_valid = 0; tx_data = 8'h00; timer = 0.
  - rx_ready = 0 while reset is high.
- Handshakes:
  - A byte transfers on a rising edge with rx_valid && rx_ready.
  - A reply transfers on a rising edge with tx_valid && tx_ready.
  - rx_ready = 1 in IDLE, GET_ADDR and GET_DATA; 0 in RESPOND. It is a pure state decode gated by !reset.
- FSM transitions:
  - IDLE, 'W' (8'h57) → GET_ADDR, with op = WRITE.
  - IDLE, 'R' (8'h52) → GET_ADDR, with op = READ.
  - IDLE, 'V' (8'h56) → RESPOND, with reply = VERSION.
  - IDLE, 8'h0D or 8'h0A → consumed silently, stay in IDLE.
  - IDLE, any other byte → RESPOND, with reply = '?' (8'h3F).
  - GET_ADDR, byte with op = READ:
    - addr < NUM_REGS: reply = reg_out[addr] sampled at that edge → RESPOND.
    - otherwise: reply = '!' (8'h21) → RESPOND.
  - GET_ADDR, byte with op = WRITE: latch addr → GET_DATA.
  - GET_DATA, byte:
    - addr < NUM_REGS: reg[addr] is written at that same edge; reply = 'K' (8'h4B).
    - otherwise: no write; reply = '!'.
    - Either way → RESPOND.
  - RESPOND: tx_valid = 1, tx_data = reply. On a tx handshake → IDLE.
- Latency: final byte of a command accepted at edge N → tx_valid = 1 in the cycle after N. Minimum command-to-next-command turnaround is 2 cycles (RESPOND + IDLE).
- Back-pressure: tx_data and tx_valid hold stable while tx_valid && !tx_ready. tx_valid never drops without a handshake.
- Timeout:
  - The timer counts every cycle spent in GET_ADDR or GET_DATA without an rx handshake, and clears on each handshake or on leaving those states.
  - When timer == TIMEOUT_CYCLES-1 and no handshake occurs that cycle, the FSM returns to IDLE with no reply and no write.
  - A handshake in that same cycle wins.
  - The timer saturates and never wraps. TIMEOUT_CYCLES = 0 means no timeout.
- Address compare uses the full 8 bits: addr 8'h04 with NUM_REGS = 4 is out of range. There is no modulo aliasing.
- Reset mid-command: the parse is lost, registers clear, and any pending reply is dropped (tx_valid falls asynchronously).
- reg_out is registered and changes only on GET_DATA write edges or on reset.

Decomposition:
- Package uart_cmd_pkg holds:
  - command constants CMD_WRITE = 8'h57, CMD_READ = 8'h52, CMD_VER = 8'h56, CHR_CR = 8'h0D, CHR_LF = 8'h0A;
  - reply constants RSP_OK = 8'h4B, RSP_BADCMD = 8'h3F, RSP_BADADDR = 8'h21;
  - the FSM state encoding {IDLE, GET_ADDR, GET_DATA, RESPOND} and the op encoding {READ, WRITE}.
- One sub-module, uart_cmd_timer, implements the saturating inter-byte timeout counter. Its inputs are clk_48mhz, reset, run and clear; its output is expired.

Test Plan:
- Write then read back: send 57 01 A5 → one reply 4B and reg_out[15:8] = A5 at the edge accepting A5. Then send 52 01 → reply A5.
- Error replies: send 52 04 with NUM_REGS = 4 → reply 21 and reg_out unchanged. Send 41 → reply 3F. Send 0D 0A 56 → only reply 01.
- Back-pressure: hold tx_ready = 0 for 10 cycles after 57 00 FF → tx_valid = 1 with tx_data = 4B held throughout, rx_ready = 0, and a byte presented meanwhile is not consumed. Release tx_ready → exactly one reply, then rx_ready = 1 on the next cycle.
- Timeout (TIMEOUT_CYCLES = 16): send 57, wait 20 idle cycles, send 02 → 02 is parsed as an unknown command and the reply is 3F with no register write. With a byte arriving at exactly cycle 15 after 57 → it is accepted as the address.
- Streaming: drive rx_valid continuously with 57 00 11 57 01 22 52 00, tx_ready = 1 → replies 4B 4B 11 in order with no loss or duplication, and reg_out = 0000_2211.
- Reset mid-command: send 57 02, assert reset for 1 cycle, send 33 → reply 3F, and reg_out stays 0 throughout.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and encodings for the UART command responder.
package uart_cmd_pkg;

  // Host command bytes
  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_VER   = 8'h56;  // 'V'
  localparam logic [7:0] CHR_CR    = 8'h0D;
  localparam logic [7:0] CHR_LF    = 8'h0A;

  // Reply bytes
  localparam logic [7:0] RSP_OK      = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_BADCMD  = 8'h3F;  // '?'
  localparam logic [7:0] RSP_BADADDR = 8'h21;  // '!'

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_ADDR = 2'd1,
    GET_DATA = 2'd2,
    RESPOND  = 2'd3
  } state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } op_e;

endpackage

// File: rtl/uart_cmd_timer.sv
// Saturating inter-byte idle counter; flags the last allowed idle cycle.
module uart_cmd_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4_800_000
) (
  input  logic clk_48mhz,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam bit          ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LAST    = ENABLED ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [31:0] count_q, count_d;

  // Next count: clear wins, otherwise count up while running and stick at all-ones
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && (count_q != '1)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = ENABLED && run && (count_q == LAST);

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-stream command parser with a small register bank and one reply per command.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for a command byte
// GET_ADDR | R/W seen, waiting for the register address byte
// GET_DATA | W + address seen, waiting for the data byte
// RESPOND  | presenting the reply byte until the host takes it
module uart_cmd_responder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4_800_000,
  parameter logic [7:0]  VERSION        = 8'h01
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [NUM_REGS*8-1:0] reg_out
);

  localparam int          IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]  NUM_REGS9 = 9'(NUM_REGS);

  state_e                     state_q, state_d;
  op_e                        op_q, op_d;
  logic [7:0]                 addr_q, addr_d;
  logic [7:0]                 reply_q, reply_d;
  logic [NUM_REGS-1:0][7:0]   regs_q, regs_d;

  logic rx_hs, tx_hs, timer_run, timer_clear, expired;

  // Full 8-bit compare: no aliasing of out-of-range addresses onto real registers
  function automatic logic in_range(input logic [7:0] a);
    return {1'b0, a} < NUM_REGS9;
  endfunction

  assign rx_ready = !reset && (state_q != RESPOND);
  assign tx_valid = (state_q == RESPOND);
  assign tx_data  = (state_q == RESPOND) ? reply_q : 8'h00;
  assign reg_out  = regs_q;

  assign rx_hs = rx_valid && rx_ready;
  assign tx_hs = tx_valid && tx_ready;

  assign timer_run   = (state_q == GET_ADDR) || (state_q == GET_DATA);
  assign timer_clear = rx_hs || !timer_run;

  uart_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_48mhz(clk_48mhz),
    .reset    (reset),
    .run      (timer_run),
    .clear    (timer_clear),
    .expired  (expired)
  );

  // Command parse: next state, latched op/address, reply byte and register writes
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    reply_d = reply_q;
    regs_d  = regs_q;
    case (state_q)
      IDLE: begin
        if (rx_hs) begin
          case (rx_data)
            CMD_WRITE: begin
              op_d    = WRITE;
              state_d = GET_ADDR;
            end
            CMD_READ: begin
              op_d    = READ;
              state_d = GET_ADDR;
            end
            CMD_VER: begin
              reply_d = VERSION;
              state_d = RESPOND;
            end
            CHR_CR, CHR_LF: begin
              state_d = IDLE;
            end
            default: begin
              reply_d = RSP_BADCMD;
              state_d = RESPOND;
            end
          endcase
        end
      end
      GET_ADDR: begin
        if (rx_hs) begin
          if (op_q == READ) begin
            reply_d = in_range(rx_data) ? regs_q[rx_data[IDX_W-1:0]] : RSP_BADADDR;
            state_d = RESPOND;
          end else begin
            addr_d  = rx_data;
            state_d = GET_DATA;
          end
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      GET_DATA: begin
        if (rx_hs) begin
          if (in_range(addr_q)) begin
            regs_d[addr_q[IDX_W-1:0]] = rx_data;
            reply_d = RSP_OK;
          end else begin
            reply_d = RSP_BADADDR;
          end
          state_d = RESPOND;
        end else if (expired) begin
          state_d = IDLE;
        end
      end
      RESPOND: begin
        if (tx_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, parse context and register bank
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= READ;
      addr_q  <= 8'h00;
      reply_q <= 8'h00;
      regs_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      reply_q <= reply_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed scoreboard bench for uart_cmd_responder (NUM_REGS=4, TIMEOUT_CYCLES=16).
module tb_uart_cmd_responder;

  logic        clk_48mhz = 1'b0;
  logic        reset     = 1'b1;
  logic [7:0]  rx_data   = 8'h00;
  logic        rx_valid  = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready  = 1'b1;
  logic [31:0] reg_out;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  uart_cmd_responder #(
    .NUM_REGS      (4),
    .TIMEOUT_CYCLES(16),
    .VERSION       (8'h01)
  ) dut (
    .clk_48mhz(clk_48mhz),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .reg_out  (reg_out)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reply monitor: every reply handshake pops one expected byte
  always @(negedge clk_48mhz) begin
    if (!reset && tx_valid && tx_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_reply: got %h expected none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          fails++;
          $display("FAIL reply: got %h expected %h", tx_data, e);
        end
      end
    end
  end

  // Present a byte from the falling edge until it is accepted; optionally keep rx_valid high
  task automatic send_byte(input logic [7:0] b, input bit hold);
    bit ok = 1'b0;
    @(negedge clk_48mhz);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_48mhz);
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL rx_accept_timeout: byte %h not accepted within 200 cycles", b);
    end
    @(posedge clk_48mhz);
    #1;
    if (!hold) rx_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !tx_valid) break;
      @(posedge clk_48mhz);
      #1;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_reg_out", reg_out, 32'h0);
    reset = 1'b0;
    @(negedge clk_48mhz);
    check("post_rst_rx_ready", rx_ready, 1);

    // Write then read back
    send_byte(8'h57, 0);
    send_byte(8'h01, 0);
    exp_q.push_back(8'h4B);
    send_byte(8'hA5, 0);
    check("write_reg1", reg_out, 32'h0000_A500);
    exp_q.push_back(8'hA5);
    send_byte(8'h52, 0);
    send_byte(8'h01, 0);
    drain();

    // Error replies and silent CR/LF
    exp_q.push_back(8'h21);
    send_byte(8'h52, 0);
    send_byte(8'h04, 0);
    exp_q.push_back(8'h3F);
    send_byte(8'h41, 0);
    send_byte(8'h0D, 0);
    send_byte(8'h0A, 0);
    exp_q.push_back(8'h01);
    send_byte(8'h56, 0);
    drain();
    check("bad_addr_no_change", reg_out, 32'h0000_A500);

    // Out-of-range write is rejected without touching the bank
    exp_q.push_back(8'h21);
    send_byte(8'h57, 0);
    send_byte(8'h04, 0);
    send_byte(8'h99, 0);
    drain();
    check("bad_write_no_change", reg_out, 32'h0000_A500);

    // Back-pressure: reply held, new byte not consumed
    @(posedge clk_48mhz);
    #1;
    tx_ready = 1'b0;
    exp_q.push_back(8'h4B);
    send_byte(8'h57, 0);
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_48mhz);
      check("bp_tx_valid", tx_valid, 1);
      check("bp_tx_data", tx_data, 8'h4B);
      check("bp_rx_ready", rx_ready, 0);
    end
    check("bp_reg_out", reg_out, 32'h0000_A5FF);
    @(posedge clk_48mhz);
    #1;
    tx_ready = 1'b1;
    exp_q.push_back(8'h3F);
    @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    check("bp_rx_ready_after", rx_ready, 1);
    @(posedge clk_48mhz);
    #1;
    rx_valid = 1'b0;
    drain();

    // Timeout: 57 then 20 idle cycles, then 02 is a fresh unknown command
    send_byte(8'h57, 0);
    repeat (20) @(posedge clk_48mhz);
    exp_q.push_back(8'h3F);
    send_byte(8'h02, 0);
    drain();
    check("timeout_no_write", reg_out, 32'h0000_A5FF);

    // Address byte arriving in the last allowed idle cycle is still accepted
    send_byte(8'h57, 0);
    repeat (15) @(posedge clk_48mhz);
    send_byte(8'h02, 0);
    exp_q.push_back(8'h4B);
    send_byte(8'h77, 0);
    drain();
    check("timeout_edge_write", reg_out, 32'h0077_A5FF);

    // Reset mid-command drops the parse and clears the bank
    send_byte(8'h57, 0);
    send_byte(8'h02, 0);
    reset = 1'b1;
    @(negedge clk_48mhz);
    check("midrst_reg_out", reg_out, 32'h0);
    check("midrst_rx_ready", rx_ready, 0);
    @(posedge clk_48mhz);
    #1;
    reset = 1'b0;
    exp_q.push_back(8'h3F);
    send_byte(8'h33, 0);
    drain();
    check("midrst_reg_after", reg_out, 32'h0);

    // Streaming with rx_valid held continuously
    send_byte(8'h57, 1);
    send_byte(8'h00, 1);
    exp_q.push_back(8'h4B);
    send_byte(8'h11, 1);
    send_byte(8'h57, 1);
    send_byte(8'h01, 1);
    exp_q.push_back(8'h4B);
    send_byte(8'h22, 1);
    send_byte(8'h52, 1);
    exp_q.push_back(8'h11);
    send_byte(8'h00, 0);
    drain();
    check("stream_reg_out", reg_out, 32'h0000_2211);

    repeat (5) @(posedge clk_48mhz);
    check("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
